sdf_bitrev_reorder: RTL and testbench

SDF_BITREV_REORDER -- requirements
Module: sdf_bitrev_reorder

---
 rtl/sdf_bitrev_reorder.sv | 112 +++++++++++
 tb/tb_sdf_bitrev_reorder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sdf_bitrev_reorder.sv
// Ping/pong reorder buffer: bit-reversed SDF FFT output frames in, natural-order bins out after N+1 cycles.
// Define REORDER_OUT_REG_EN to add one more output register stage (latency N+2).
module sdf_bitrev_reorder #(
  parameter int LOG2N = 4,
  parameter int DW    = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             di_en,
  input  logic [DW-1:0]    di_re,
  input  logic [DW-1:0]    di_im,
  output logic             do_en,
  output logic [DW-1:0]    do_re,
  output logic [DW-1:0]    do_im,
  output logic [LOG2N-1:0] do_idx
);

  localparam int N = 1 << LOG2N;

  logic [2*DW-1:0]  mem [0:1][0:N-1];
  logic [LOG2N:0]   wcnt;
  logic [LOG2N-1:0] waddr;
  logic [LOG2N-1:0] rcnt;
  logic             wbank;
  logic             rbank;
  logic             ract;
  logic             frame_done;
  logic [2*DW-1:0]  rd_word;

  logic             s1_en;
  logic [DW-1:0]    s1_re;
  logic [DW-1:0]    s1_im;
  logic [LOG2N-1:0] s1_idx;

  always_comb begin
    waddr = '0;
    for (int i = 0; i < LOG2N; i++) waddr[i] = wcnt[LOG2N-1-i];
  end

  assign frame_done = di_en && (wcnt == (LOG2N+1)'(N-1));
  assign rd_word    = mem[rbank][rcnt];

  // Bank storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (di_en) mem[wbank][waddr] <= {di_re, di_im};
  end

  // wcnt restarts at 0 once a frame completes so back-to-back frames line up.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wcnt  <= '0;
      wbank <= 1'b0;
      rbank <= 1'b0;
      ract  <= 1'b0;
      rcnt  <= '0;
    end else begin
      if (!di_en || frame_done) wcnt <= '0;
      else                      wcnt <= wcnt + 1'b1;

      if (frame_done) begin
        wbank <= ~wbank;
        rbank <= wbank;
        ract  <= 1'b1;
        rcnt  <= '0;
      end else if (ract) begin
        rcnt <= rcnt + 1'b1;
        if (rcnt == LOG2N'(N-1)) ract <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_en  <= 1'b0;
      s1_re  <= '0;
      s1_im  <= '0;
      s1_idx <= '0;
    end else if (ract) begin
      s1_en  <= 1'b1;
      s1_re  <= rd_word[2*DW-1:DW];
      s1_im  <= rd_word[DW-1:0];
      s1_idx <= rcnt;
    end else begin
      s1_en  <= 1'b0;
      s1_re  <= '0;
      s1_im  <= '0;
      s1_idx <= '0;
    end
  end

`ifdef REORDER_OUT_REG_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      do_en  <= 1'b0;
      do_re  <= '0;
      do_im  <= '0;
      do_idx <= '0;
    end else begin
      do_en  <= s1_en;
      do_re  <= s1_re;
      do_im  <= s1_im;
      do_idx <= s1_idx;
    end
  end
`else
  assign do_en  = s1_en;
  assign do_re  = s1_re;
  assign do_im  = s1_im;
  assign do_idx = s1_idx;
`endif

endmodule

// File: tb/tb_sdf_bitrev_reorder.sv
// Bench for sdf_bitrev_reorder (N=16, DW=16): expected bursts built from a hand-written reorder table.
module tb_sdf_bitrev_reorder;

  localparam int LOG2N = 4;
  localparam int N     = 16;
  localparam int DW    = 16;
`ifdef REORDER_OUT_REG_EN
  localparam int LAT = N + 2;
`else
  localparam int LAT = N + 1;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          di_en;
  logic [DW-1:0] di_re, di_im;
  logic          do_en;
  logic [DW-1:0] do_re, do_im;
  logic [LOG2N-1:0] do_idx;

  sdf_bitrev_reorder #(.LOG2N(LOG2N), .DW(DW)) dut (
    .clk(clk), .rstn(rstn), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .do_en(do_en), .do_re(do_re), .do_im(do_im), .do_idx(do_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] exp_re;
    logic [15:0] exp_im;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [15:0] re;
    logic [15:0] im;
    logic [3:0]  idx;
  } obs_t;

  vec_t tbl [16];
  obs_t got [$];
  obs_t exp_q [$];
  int   n_chk = 0;
  int   n_bad = 0;

  // Capture every valid output; idle cycles must present all-zero data.
  always @(negedge clk) begin
    if (do_en === 1'b1) begin
      got.push_back('{cyc, do_re, do_im, do_idx});
    end else begin
      n_chk++;
      if (do_en !== 1'b0 || do_re !== '0 || do_im !== '0 || do_idx !== '0) begin
        n_bad++;
        $display("FAIL idle_zero cyc=%0d: en=%b re=%h im=%h idx=%h, want all 0",
                 cyc, do_en, do_re, do_im, do_idx);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
    n_chk++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, g, e);
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      di_en = 1'b0;
      di_re = '0;
      di_im = '0;
    end
  endtask

  task automatic send_frame(input int base, input int n, output int c0);
    c0 = 0;
    for (int w = 0; w < n; w++) begin
      @(negedge clk);
      if (w == 0) c0 = cyc;
      di_en = 1'b1;
      di_re = 16'(base + w);
      di_im = 16'(-(base + w));
    end
  endtask

  task automatic add_frame(input int c0, input int base);
    obs_t e;
    for (int k = 0; k < N; k++) begin
      e.cyc = c0 + LAT + k;
      e.idx = tbl[k].idx;
      e.re  = tbl[k].exp_re + 16'(base);
      e.im  = tbl[k].exp_im - 16'(base);
      exp_q.push_back(e);
    end
  endtask

  task automatic cmp(input string nm);
    int n;
    chk({nm, "_count"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_chk++;
      if (got[i].cyc != exp_q[i].cyc || got[i].idx !== exp_q[i].idx ||
          got[i].re !== exp_q[i].re || got[i].im !== exp_q[i].im) begin
        n_bad++;
        $display("FAIL %s[%0d]: got cyc=%0d idx=%0d re=%h im=%h want cyc=%0d idx=%0d re=%h im=%h",
                 nm, i, got[i].cyc, got[i].idx, got[i].re, got[i].im,
                 exp_q[i].cyc, exp_q[i].idx, exp_q[i].re, exp_q[i].im);
      end
    end
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    int c0, c1, c2;
    int hit;
    int rv [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    for (int k = 0; k < 16; k++) begin
      tbl[k].idx    = 4'(k);
      tbl[k].exp_re = 16'(rv[k]);
      tbl[k].exp_im = 16'(-rv[k]);
    end

    rstn  = 1'b0;
    di_en = 1'b0;
    di_re = '0;
    di_im = '0;
    #2;
    chk("rst_do_en", 32'(do_en), 0);
    chk("rst_do_re", 32'(do_re), 0);
    chk("rst_do_im", 32'(do_im), 0);
    chk("rst_do_idx", 32'(do_idx), 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    idle(3);
    got.delete();

    // single frame, ramp 0
    send_frame(0, N, c0);
    add_frame(c0, 0);
    idle(N + 8);
    cmp("single");

    // three back-to-back frames
    send_frame(0, N, c0);
    send_frame(100, N, c1);
    send_frame(200, N, c2);
    add_frame(c0, 0);
    add_frame(c1, 100);
    add_frame(c2, 200);
    idle(N + 8);
    cmp("b2b");

    // aborted partial frame followed by a full frame
    send_frame(50, 5, c0);
    idle(1);
    send_frame(300, N, c1);
    add_frame(c1, 300);
    idle(N + 8);
    cmp("partial");

    // two frames separated by 10 idle cycles
    send_frame(400, N, c0);
    idle(10);
    send_frame(600, N, c1);
    add_frame(c0, 400);
    add_frame(c1, 600);
    idle(N + 8);
    cmp("gap");

    // reset pulsed in the middle of a readout
    send_frame(700, N, c0);
    add_frame(c0, 700);
    while (exp_q.size() > 8) void'(exp_q.pop_back());
    idle(1);
    hit = 0;
    for (int t = 0; t < 60 && hit == 0; t++) begin
      @(negedge clk);
      if (do_en === 1'b1 && do_idx === 4'd7) hit = 1;
    end
    chk("rst_mid_reach_idx7", 32'(hit), 1);
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_do_en", 32'(do_en), 0);
    chk("rst_mid_do_re", 32'(do_re), 0);
    chk("rst_mid_do_im", 32'(do_im), 0);
    chk("rst_mid_do_idx", 32'(do_idx), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    idle(40);
    send_frame(800, N, c1);
    add_frame(c1, 800);
    idle(N + 8);
    cmp("rst_mid");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
